// File: rtl/elastic_op_pkg.sv
`default_nettype none
// ============================================================================
// Module : elastic_op_pkg
// Brief  : Opcode encodings shared by the elastic operator node and its ALU,
//          plus a constant-evaluable ceil(log2) helper for pointer sizing.
// Config : ELASTIC_OP_STATS_EN (used by elastic_async_operator, not here)
// Rev    : 1.0  initial release
// ============================================================================
package elastic_op_pkg;

    localparam logic [3:0] OP_REG  = 4'd0;
    localparam logic [3:0] OP_IN   = 4'd1;
    localparam logic [3:0] OP_OUT  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_SUBI = 4'd7;
    localparam logic [3:0] OP_MULI = 4'd8;

    // ceil(log2(value)); value must be >= 1
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elastic_op_alu.sv
`default_nettype none
// ============================================================================
// Module : elastic_op_alu
// Brief  : Combinational operator of the elastic node. Operand i lives at
//          opnd[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]. All arithmetic is modulo
//          2^DATA_WIDTH. *I ops combine operand 0 with IMMEDIATE.
// Ports  : opnd   in  INPUT_SIZE*DATA_WIDTH  latched operands
//          result out DATA_WIDTH             operator output
// Config : none
// Rev    : 1.0  initial release
// ============================================================================
module elastic_op_alu
    import elastic_op_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    INPUT_SIZE = 2,
    parameter logic [3:0]            OP         = OP_ADD,
    parameter logic [DATA_WIDTH-1:0] IMMEDIATE  = '0
) (
    input  logic [INPUT_SIZE*DATA_WIDTH-1:0] opnd,
    output logic [DATA_WIDTH-1:0]            result
);

    always_comb begin
        result = opnd[DATA_WIDTH-1:0];
        case (OP)
            OP_ADD: begin
                for (int i = 1; i < INPUT_SIZE; i++)
                    result = result + opnd[i*DATA_WIDTH +: DATA_WIDTH];
            end
            OP_SUB: begin
                for (int i = 1; i < INPUT_SIZE; i++)
                    result = result - opnd[i*DATA_WIDTH +: DATA_WIDTH];
            end
            OP_MUL: begin
                for (int i = 1; i < INPUT_SIZE; i++)
                    result = result * opnd[i*DATA_WIDTH +: DATA_WIDTH];
            end
            OP_ADDI: result = opnd[DATA_WIDTH-1:0] + IMMEDIATE;
            OP_SUBI: result = opnd[DATA_WIDTH-1:0] - IMMEDIATE;
            OP_MULI: result = opnd[DATA_WIDTH-1:0] * IMMEDIATE;
            default: result = opnd[DATA_WIDTH-1:0]; // REG / IN / OUT pass-through
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/elastic_async_operator.sv
`default_nettype none
// ============================================================================
// Module : elastic_async_operator
// Brief  : Dataflow node: joins INPUT_SIZE request/ack operand channels,
//          computes one op, queues results in a DEPTH-entry buffer and forks
//          them to OUTPUT_SIZE independently handshaked consumers. Each
//          consumer owns a read pointer; the slowest one throttles firing.
// Ports  : clk, rst (async, active-high)
//          req_l/ack_l/din      upstream operand channels
//          req_r/ack_r/dout     downstream consumer channels
//          fire_count/stall_count  (only with ELASTIC_OP_STATS_EN)
// Config : ELASTIC_OP_STATS_EN adds the fire/stall counters
// Rev    : 1.0  initial release
// ============================================================================
module elastic_async_operator
    import elastic_op_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    INPUT_SIZE  = 2,
    parameter int                    OUTPUT_SIZE = 2,
    parameter int                    DEPTH       = 4,
    parameter logic [3:0]            OP          = OP_ADD,
    parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [INPUT_SIZE-1:0]             req_l,
    input  logic [INPUT_SIZE-1:0]             ack_l,
    input  logic [INPUT_SIZE*DATA_WIDTH-1:0]  din,
    input  logic [OUTPUT_SIZE-1:0]            req_r,
    output logic [OUTPUT_SIZE-1:0]            ack_r,
    output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] dout
`ifdef ELASTIC_OP_STATS_EN
    ,
    output logic [31:0]                       fire_count,
    output logic [31:0]                       stall_count
`endif
);

    localparam int PW = clog2(DEPTH);
    typedef logic [PW:0] ptr_t;   // one extra bit separates full from empty

    logic [INPUT_SIZE-1:0]             req_l_q, req_l_d;
    logic [INPUT_SIZE-1:0]             has_q, has_d;
    logic [INPUT_SIZE*DATA_WIDTH-1:0]  opnd_q, opnd_d;
    logic [DATA_WIDTH-1:0]             mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]             mem_d [DEPTH];
    ptr_t                              wr_ptr_q, wr_ptr_d;
    ptr_t                              rd_ptr_q [OUTPUT_SIZE];
    ptr_t                              rd_ptr_d [OUTPUT_SIZE];
    ptr_t                              avail    [OUTPUT_SIZE];
    logic [OUTPUT_SIZE-1:0]            ack_r_q, ack_r_d;
    logic [OUTPUT_SIZE*DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0]             alu_result;
    logic                              full;
    logic                              fire;

    elastic_op_alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .INPUT_SIZE (INPUT_SIZE),
        .OP         (OP),
        .IMMEDIATE  (IMMEDIATE)
    ) u_alu (
        .opnd   (opnd_q),
        .result (alu_result)
    );

    // Occupancy is judged per consumer from registered pointers only, so a
    // slot freed by a read this cycle is not reusable until the next one.
    always_comb begin
        full = 1'b0;
        for (int j = 0; j < OUTPUT_SIZE; j++) begin
            avail[j] = wr_ptr_q - rd_ptr_q[j];
            if (avail[j] == ptr_t'(DEPTH))
                full = 1'b1;
        end
    end

    assign fire = (&has_q) & ~full;

    always_comb begin
        req_l_d  = req_l_q;
        has_d    = has_q;
        opnd_d   = opnd_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        ack_r_d  = '0;
        dout_d   = dout_q;

        // Operand join; an ack on an already-filled channel is dropped.
        for (int i = 0; i < INPUT_SIZE; i++) begin
            if (ack_l[i] && !has_q[i]) begin
                opnd_d[i*DATA_WIDTH +: DATA_WIDTH] = din[i*DATA_WIDTH +: DATA_WIDTH];
                has_d[i]   = 1'b1;
                req_l_d[i] = 1'b0;
            end else if (!has_q[i] && !req_l_q[i]) begin
                req_l_d[i] = 1'b1;
            end
        end

        if (fire) begin
            mem_d[wr_ptr_q[PW-1:0]] = alu_result;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
            has_d    = '0;
        end

        // Fork: each consumer drains in FIFO order, at most every other cycle.
        for (int j = 0; j < OUTPUT_SIZE; j++) begin
            rd_ptr_d[j] = rd_ptr_q[j];
            if (req_r[j] && (avail[j] != '0) && !ack_r_q[j]) begin
                ack_r_d[j] = 1'b1;
                dout_d[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q[j][PW-1:0]];
                rd_ptr_d[j] = rd_ptr_q[j] + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_l_q  <= '0;
            has_q    <= '0;
            opnd_q   <= '0;
            wr_ptr_q <= '0;
            ack_r_q  <= '0;
            dout_q   <= '0;
            for (int j = 0; j < OUTPUT_SIZE; j++)
                rd_ptr_q[j] <= '0;
        end else begin
            req_l_q  <= req_l_d;
            has_q    <= has_d;
            opnd_q   <= opnd_d;
            wr_ptr_q <= wr_ptr_d;
            ack_r_q  <= ack_r_d;
            dout_q   <= dout_d;
            for (int j = 0; j < OUTPUT_SIZE; j++)
                rd_ptr_q[j] <= rd_ptr_d[j];
        end
    end

    // Buffer storage carries no reset: pointers alone define its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign req_l = req_l_q;
    assign ack_r = ack_r_q;
    assign dout  = dout_q;

`ifdef ELASTIC_OP_STATS_EN
    logic [31:0] fire_count_q, fire_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fire_count_d  = fire_count_q;
        stall_count_d = stall_count_q;
        if (fire)
            fire_count_d = fire_count_q + 32'd1;
        if ((&has_q) && full)
            stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            fire_count_q  <= fire_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fire_count  = fire_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_elastic_async_operator.sv
`default_nettype none
// ============================================================================
// Module : tb_elastic_async_operator
// Brief  : Directed self-checking bench. Five node instances cover ADD, a
//          stalled 2-way fork (ADDI 0), SUBI wrap-around, MUL and 3-input
//          SUB, and asynchronous reset with results still queued.
// Config : ELASTIC_OP_STATS_EN also checks fire_count / stall_count
// Rev    : 1.0  initial release
// ============================================================================
module tb_elastic_async_operator;
    import elastic_op_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // a: 2-in ADD, 1 out
    logic [1:0]  a_req_l, a_ack_l;
    logic [63:0] a_din;
    logic [0:0]  a_req_r, a_ack_r;
    logic [31:0] a_dout;
    // f: 1-in ADDI 0, 2 outs
    logic [0:0]  f_req_l, f_ack_l;
    logic [31:0] f_din;
    logic [1:0]  f_req_r, f_ack_r;
    logic [63:0] f_dout;
    // s: 1-in SUBI 2
    logic [0:0]  s_req_l, s_ack_l;
    logic [31:0] s_din;
    logic [0:0]  s_req_r, s_ack_r;
    logic [31:0] s_dout;
    // m: 2-in MUL
    logic [1:0]  m_req_l, m_ack_l;
    logic [63:0] m_din;
    logic [0:0]  m_req_r, m_ack_r;
    logic [31:0] m_dout;
    // b: 3-in SUB
    logic [2:0]  b_req_l, b_ack_l;
    logic [95:0] b_din;
    logic [0:0]  b_req_r, b_ack_r;
    logic [31:0] b_dout;

`ifdef ELASTIC_OP_STATS_EN
    logic [31:0] fc [5];
    logic [31:0] sc [5];
`endif

    elastic_async_operator #(.INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(4), .OP(OP_ADD)) u_a (
        .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din),
        .req_r(a_req_r), .ack_r(a_ack_r), .dout(a_dout)
`ifdef ELASTIC_OP_STATS_EN
        , .fire_count(fc[0]), .stall_count(sc[0])
`endif
    );
    elastic_async_operator #(.INPUT_SIZE(1), .OUTPUT_SIZE(2), .DEPTH(4), .OP(OP_ADDI), .IMMEDIATE(32'd0)) u_f (
        .clk(clk), .rst(rst), .req_l(f_req_l), .ack_l(f_ack_l), .din(f_din),
        .req_r(f_req_r), .ack_r(f_ack_r), .dout(f_dout)
`ifdef ELASTIC_OP_STATS_EN
        , .fire_count(fc[1]), .stall_count(sc[1])
`endif
    );
    elastic_async_operator #(.INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(4), .OP(OP_SUBI), .IMMEDIATE(32'd2)) u_s (
        .clk(clk), .rst(rst), .req_l(s_req_l), .ack_l(s_ack_l), .din(s_din),
        .req_r(s_req_r), .ack_r(s_ack_r), .dout(s_dout)
`ifdef ELASTIC_OP_STATS_EN
        , .fire_count(fc[2]), .stall_count(sc[2])
`endif
    );
    elastic_async_operator #(.INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(4), .OP(OP_MUL)) u_m (
        .clk(clk), .rst(rst), .req_l(m_req_l), .ack_l(m_ack_l), .din(m_din),
        .req_r(m_req_r), .ack_r(m_ack_r), .dout(m_dout)
`ifdef ELASTIC_OP_STATS_EN
        , .fire_count(fc[3]), .stall_count(sc[3])
`endif
    );
    elastic_async_operator #(.INPUT_SIZE(3), .OUTPUT_SIZE(1), .DEPTH(4), .OP(OP_SUB)) u_b (
        .clk(clk), .rst(rst), .req_l(b_req_l), .ack_l(b_ack_l), .din(b_din),
        .req_r(b_req_r), .ack_r(b_ack_r), .dout(b_dout)
`ifdef ELASTIC_OP_STATS_EN
        , .fire_count(fc[4]), .stall_count(sc[4])
`endif
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_a_req();
        for (int n = 0; n < 20 && a_req_l !== 2'b11; n++) tick();
        check_vec("a_req_l_up", 32'(a_req_l), 32'h3);
    endtask

    // Offer one operand pair to instance a as a single-cycle ack pulse.
    task automatic feed_a(input logic [31:0] x, input logic [31:0] y);
        wait_a_req();
        a_ack_l = 2'b11;
        a_din   = {y, x};
        tick();
        a_ack_l = 2'b00;
    endtask

    // Wait (bounded) for the single consumer of instance a to be acked.
    task automatic wait_a_ack(input string tag, input logic [31:0] exp);
        for (int n = 0; n < 20 && a_ack_r !== 1'b1; n++) tick();
        check_vec({tag, "_ack"}, 32'(a_ack_r), 32'h1);
        check_vec(tag, a_dout, exp);
    endtask

    int          k, n0, n1, stray1, got, cyc_l, first1, c0_5;
    logic [31:0] mul_a [2] = '{32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] mul_b [2] = '{32'h0001_0000, 32'h0000_0002};
    logic [31:0] mul_e [2] = '{32'h0000_0000, 32'hFFFF_FFFE};
    logic [31:0] sub_v [2][3] = '{'{32'd5, 32'd7, 32'd1}, '{32'd100, 32'd1, 32'd2}};
    logic [31:0] sub_e [2] = '{32'hFFFF_FFFD, 32'd97};

    initial begin
        a_ack_l = '0; a_din = '0; a_req_r = '0;
        f_ack_l = '0; f_din = '0; f_req_r = '0;
        s_ack_l = '0; s_din = '0; s_req_r = '0;
        m_ack_l = '0; m_din = '0; m_req_r = '0;
        b_ack_l = '0; b_din = '0; b_req_r = '0;
        repeat (3) tick();

        // Reset state
        check_vec("rst_req_l", 32'(a_req_l), 32'h0);
        check_vec("rst_ack_r", 32'(a_ack_r), 32'h0);
        check_vec("rst_dout",  a_dout, 32'h0);
        check_vec("rst_f_dout_hi", f_dout[63:32], 32'h0);
        rst = 1'b0;

        // 1: ADD 3+4, ack_r two edges after the operand ack edge
        a_req_r = 1'b1;
        wait_a_req();
        a_ack_l = 2'b11;
        a_din   = {32'd4, 32'd3};
        tick();
        a_ack_l = 2'b00;
        check_vec("add_lat_e1", 32'(a_ack_r), 32'h0);
        tick();
        check_vec("add_lat_e2", 32'(a_ack_r), 32'h0);
        tick();
        check_vec("add_lat_e3", 32'(a_ack_r), 32'h1);
        check_vec("add_dout", a_dout, 32'd7);
        tick();
        check_vec("add_ack_pulse", 32'(a_ack_r), 32'h0);
        check_vec("add_dout_hold", a_dout, 32'd7);

        // 2: fork with consumer 1 held off -> stall after 4 fires
        f_req_r = 2'b01; k = 1; n0 = 0; stray1 = 0; cyc_l = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (f_ack_r[0]) begin
                check_vec("fork_c0_early", f_dout[31:0], 32'(n0 + 1));
                n0++;
            end
            if (f_ack_r[1]) stray1++;
            if (f_req_l[0] && k <= 5) begin
                f_ack_l = 1'b1;
                f_din   = 32'(k);
                if (k == 5) cyc_l = cyc + 1;
                k++;
            end else begin
                f_ack_l = 1'b0;
            end
        end
        f_ack_l = 1'b0;
        check_vec("fork_c0_count_stalled", 32'(n0), 32'd4);
        check_vec("fork_all_operands_taken", 32'(k), 32'd6);
        check_vec("fork_req_l_held_low", 32'(f_req_l), 32'h0);
        check_vec("fork_c1_idle", 32'(stray1), 32'd0);

        f_req_r = 2'b11; n1 = 0; first1 = 0; c0_5 = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (f_ack_r[1]) begin
                check_vec("fork_c1_data", f_dout[63:32], 32'(n1 + 1));
                if (n1 == 0) first1 = cyc;
                n1++;
            end
            if (f_ack_r[0]) begin
                check_vec("fork_c0_data", f_dout[31:0], 32'(n0 + 1));
                if (n0 == 4) c0_5 = cyc;
                n0++;
            end
        end
        check_vec("fork_c1_count", 32'(n1), 32'd5);
        check_vec("fork_c0_count", 32'(n0), 32'd5);
        check_vec("fork_5th_after_c1", 32'(c0_5 - first1), 32'd2);
`ifdef ELASTIC_OP_STATS_EN
        check_vec("stats_fire", fc[1], 32'd5);
        check_vec("stats_stall", sc[1], 32'(first1 - cyc_l));
        check_vec("stats_add_fire", fc[0], 32'd1);
`endif

        // 3: SUBI 2 over 0..9, pointers wrap
        s_req_r = 1'b1; k = 0; got = 0;
        for (int c = 0; c < 200 && got < 10; c++) begin
            tick();
            if (s_ack_r[0]) begin
                check_vec("subi_dout", s_dout, 32'(got) - 32'd2);
                got++;
            end
            if (s_req_l[0] && k < 10) begin
                s_ack_l = 1'b1;
                s_din   = 32'(k);
                k++;
            end else begin
                s_ack_l = 1'b0;
            end
        end
        s_ack_l = 1'b0;
        check_vec("subi_count", 32'(got), 32'd10);

        // 4: MUL low bits, 3-input SUB
        m_req_r = 1'b1;
        for (int v = 0; v < 2; v++) begin
            for (int n = 0; n < 20 && m_req_l !== 2'b11; n++) tick();
            m_ack_l = 2'b11;
            m_din   = {mul_b[v], mul_a[v]};
            tick();
            m_ack_l = 2'b00;
            for (int n = 0; n < 20 && m_ack_r !== 1'b1; n++) tick();
            check_vec("mul_dout", m_dout, mul_e[v]);
        end
        b_req_r = 1'b1;
        for (int v = 0; v < 2; v++) begin
            for (int n = 0; n < 20 && b_req_l !== 3'b111; n++) tick();
            b_ack_l = 3'b111;
            b_din   = {sub_v[v][2], sub_v[v][1], sub_v[v][0]};
            tick();
            b_ack_l = 3'b000;
            for (int n = 0; n < 20 && b_ack_r !== 1'b1; n++) tick();
            check_vec("sub3_dout", b_dout, sub_e[v]);
        end

        // 5: async reset with two results still queued
        tick();
        a_req_r = 1'b0;
        feed_a(32'd1, 32'd2);
        feed_a(32'd3, 32'd4);
        feed_a(32'd5, 32'd6);
        repeat (4) tick();
        a_req_r = 1'b1;
        wait_a_ack("rst_pre_q0", 32'd3);
        #2 rst = 1'b1;
        #1;
        check_vec("async_rst_ack_r", 32'(a_ack_r), 32'h0);
        check_vec("async_rst_req_l", 32'(a_req_l), 32'h0);
        check_vec("async_rst_dout", a_dout, 32'h0);
        tick();
        rst = 1'b0;
        got = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (a_ack_r[0]) got++;
        end
        check_vec("rst_queue_discarded", 32'(got), 32'd0);
        feed_a(32'd10, 32'd20);
        wait_a_ack("rst_fresh_result", 32'd30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
